// File: rtl/router_out_arbiter_pkg.sv
// Shared types and sizes for the router output-channel arbiter.
package router_out_arbiter_pkg;

    localparam int unsigned N     = 32;
    localparam int unsigned P     = 5;
    localparam int unsigned IDX_W = $clog2(P);

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_EAST  = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2,
        ST_RET  = 2'd3
    } arb_state_t;

    typedef logic [N-1:0]     word_t;
    typedef logic [P-1:0]     port_vec_t;
    typedef logic [IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/router_out_arbiter_if.sv
// Upstream/downstream handshake bundle of one router output channel.
interface router_out_arbiter_if;
    import router_out_arbiter_pkg::*;

    port_vec_t          in_req;
    logic [P-1:0][N-1:0] in_data;
    port_vec_t          in_ack;
    logic               out_req;
    word_t              out_data;
    logic               out_ack;
    port_vec_t          grant;
    logic               busy;

    // Arbiter side
    modport master (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, grant, busy
    );

    // Environment side: input ports and downstream link
    modport slave (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, grant, busy
    );

endinterface

// File: rtl/router_out_arbiter_rr.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module router_out_arbiter_rr
    import router_out_arbiter_pkg::*;
(
    input  port_vec_t req,
    input  port_idx_t ptr,
    output port_vec_t gnt,
    output port_idx_t idx,
    output logic      any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned off = 1; off <= P; off++) begin
            if (!any && req[port_idx_t'((32'(ptr) + off) % P)]) begin
                any = 1'b1;
                idx = port_idx_t'((32'(ptr) + off) % P);
            end
        end
        gnt = any ? (port_vec_t'(1) << idx) : '0;
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Round-robin arbiter and four-phase sequencer for one router output link.
module router_out_arbiter
    import router_out_arbiter_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    router_out_arbiter_if.master bus
);

    arb_state_t state_q, state_n;
    port_idx_t  ptr_q, ptr_n;
    port_idx_t  winner_q, winner_n;
    logic       out_req_q, out_req_n;
    word_t      out_data_q, out_data_n;
    port_vec_t  in_ack_q, in_ack_n;
    port_vec_t  grant_q, grant_n;
    logic       busy_q;

    port_vec_t  rr_gnt;
    port_idx_t  rr_idx;
    logic       rr_any;

    router_out_arbiter_rr u_rr (
        .req (bus.in_req),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // Next-state and next-output values; every output is registered below.
    always_comb begin
        state_n    = state_q;
        ptr_n      = ptr_q;
        winner_n   = winner_q;
        out_req_n  = out_req_q;
        out_data_n = out_data_q;
        in_ack_n   = in_ack_q;
        grant_n    = grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    winner_n   = rr_idx;
                    out_data_n = bus.in_data[rr_idx];
                    grant_n    = rr_gnt;
                    out_req_n  = 1'b1;
                    state_n    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.out_ack) begin
                    out_req_n = 1'b0;
                    state_n   = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!bus.out_ack) begin
                    in_ack_n = grant_q;
                    state_n  = ST_RET;
                end
            end
            ST_RET: begin
                // A winner that already dropped in_req gets a one-cycle ack pulse
                if (!bus.in_req[winner_q]) begin
                    in_ack_n = '0;
                    ptr_n    = winner_q;
                    grant_n  = '0;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= port_idx_t'(P - 1);
            winner_q   <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            in_ack_q   <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            ptr_q      <= ptr_n;
            winner_q   <= winner_n;
            out_req_q  <= out_req_n;
            out_data_q <= out_data_n;
            in_ack_q   <= in_ack_n;
            grant_q    <= grant_n;
            busy_q     <= (state_n != ST_IDLE);
        end
    end

    assign bus.out_req  = out_req_q;
    assign bus.out_data = out_data_q;
    assign bus.in_ack   = in_ack_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed self-checking bench for router_out_arbiter.
module tb_router_out_arbiter;
    import router_out_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    router_out_arbiter_if bus ();

    router_out_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(bus.in_ack) > 1) begin
                errors++;
                $display("FAIL ack_onehot in_ack=%b expected at most one bit", bus.in_ack);
            end
        end
    end

    task automatic apply_reset();
        rst         = 1'b1;
        bus.in_req  = '0;
        bus.out_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Plays the upstream/downstream handshake and reports what it observed.
    task automatic handshake(input bit early, input port_vec_t raise,
                             output port_vec_t g, output word_t d,
                             output int lat, output int ack_cycles, output bit ok);
        int n;
        ok = 1'b1;
        ack_cycles = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.out_req !== 1'b1 && n < 20);
        lat = n;
        if (bus.out_req !== 1'b1) ok = 1'b0;
        g = bus.grant;
        d = bus.out_data;
        bus.in_req = bus.in_req | raise;
        if (early) bus.in_req = bus.in_req & ~g;
        bus.out_ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.out_req !== 1'b0 && n < 20);
        if (bus.out_req !== 1'b0) ok = 1'b0;
        bus.out_ack = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.in_ack === '0 && n < 20);
        if (bus.in_ack !== g) ok = 1'b0;
        bus.in_req = bus.in_req & ~g;
        n = 0;
        while (bus.in_ack !== '0 && n < 20) begin
            ack_cycles++;
            @(negedge clk);
            n++;
        end
        if (bus.in_ack !== '0) ok = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.out_req !== 1'b0) begin errors++; $display("FAIL reset_out_req got=%b exp=0", bus.out_req); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.in_ack !== 5'b0) begin errors++; $display("FAIL reset_in_ack got=%b exp=00000", bus.in_ack); end
        checks++; if (bus.grant !== 5'b0) begin errors++; $display("FAIL reset_grant got=%b exp=00000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_single();
        port_vec_t g; word_t d; int lat; int ac; bit ok;
        bus.in_data[2] = 32'hA5A5_0001;
        bus.in_req = 5'b00100;
        handshake(1'b0, '0, g, d, lat, ac, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_handshake got=0 exp=1"); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency got=%0d exp=1", lat); end
        checks++; if (g !== 5'b00100) begin errors++; $display("FAIL single_grant got=%b exp=00100", g); end
        checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got=%h exp=a5a50001", d); end
        checks++; if (ac !== 1) begin errors++; $display("FAIL single_ack_len got=%0d exp=1", ac); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
        checks++; if (bus.out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_hold got=%h exp=a5a50001", bus.out_data); end
    endtask

    task automatic test_round_robin();
        port_vec_t g; word_t d; int lat; int ac; bit ok;
        int exp_port[6] = '{0, 1, 2, 3, 4, 0};
        port_vec_t exp_g;
        word_t exp_d;
        for (int i = 0; i < P; i++) bus.in_data[i] = 32'hD000_0000 | 32'(i);
        apply_reset();
        bus.in_req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            handshake(1'b0, '0, g, d, lat, ac, ok);
            exp_g = port_vec_t'(1) << exp_port[k];
            exp_d = 32'hD000_0000 | 32'(exp_port[k]);
            checks++; if (!ok) begin errors++; $display("FAIL rr_handshake[%0d] got=0 exp=1", k); end
            checks++; if (g !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, g, exp_g); end
            checks++; if (d !== exp_d) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, d, exp_d); end
            bus.in_req = 5'b11111;
        end
        bus.in_req = '0;
        @(negedge clk);
    endtask

    task automatic test_ptr_wrap();
        port_vec_t g; word_t d; int lat; int ac; bit ok;
        bus.in_req = 5'b10000;
        handshake(1'b0, '0, g, d, lat, ac, ok);
        checks++; if (!ok || g !== 5'b10000) begin errors++; $display("FAIL wrap_first got=%b ok=%0d exp=10000", g, ok); end
        bus.in_req = 5'b01001;
        handshake(1'b0, '0, g, d, lat, ac, ok);
        checks++; if (!ok || g !== 5'b00001) begin errors++; $display("FAIL wrap_second got=%b ok=%0d exp=00001", g, ok); end
        checks++; if (d !== 32'hD000_0000) begin errors++; $display("FAIL wrap_data got=%h exp=d0000000", d); end
        bus.in_req = '0;
        @(negedge clk);
    endtask

    task automatic test_late_request();
        port_vec_t g; word_t d; int lat; int ac; bit ok;
        bus.in_data[3] = 32'h3333_CAFE;
        bus.in_data[1] = 32'h1111_BEEF;
        bus.in_req = 5'b01000;
        handshake(1'b0, 5'b00010, g, d, lat, ac, ok);
        checks++; if (!ok || g !== 5'b01000) begin errors++; $display("FAIL late_first_grant got=%b ok=%0d exp=01000", g, ok); end
        checks++; if (bus.out_data !== 32'h3333_CAFE) begin errors++; $display("FAIL late_first_word got=%h exp=3333cafe", bus.out_data); end
        checks++; if (bus.busy !== 1'b0 || bus.in_req !== 5'b00010) begin errors++; $display("FAIL late_pending got busy=%b req=%b exp busy=0 req=00010", bus.busy, bus.in_req); end
        handshake(1'b0, '0, g, d, lat, ac, ok);
        checks++; if (!ok || g !== 5'b00010) begin errors++; $display("FAIL late_second_grant got=%b ok=%0d exp=00010", g, ok); end
        checks++; if (d !== 32'h1111_BEEF) begin errors++; $display("FAIL late_second_data got=%h exp=1111beef", d); end
    endtask

    task automatic test_reset_mid();
        port_vec_t g; word_t d; int lat; int ac; bit ok;
        int n;
        bus.in_req = 5'b00100;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.out_req !== 1'b1 && n < 20);
        bus.out_ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.out_req !== 1'b0 && n < 20);
        checks++; if (bus.busy !== 1'b1 || bus.grant !== 5'b00100) begin errors++; $display("FAIL midrst_in_drop got busy=%b grant=%b exp busy=1 grant=00100", bus.busy, bus.grant); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_req !== 1'b0) begin errors++; $display("FAIL midrst_out_req got=%b exp=0", bus.out_req); end
        checks++; if (bus.in_ack !== 5'b0) begin errors++; $display("FAIL midrst_in_ack got=%b exp=00000", bus.in_ack); end
        checks++; if (bus.grant !== 5'b0) begin errors++; $display("FAIL midrst_grant got=%b exp=00000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL midrst_out_data got=%h exp=0", bus.out_data); end
        rst = 1'b0;
        bus.out_ack = 1'b0;
        bus.in_req = 5'b01001;
        handshake(1'b0, '0, g, d, lat, ac, ok);
        checks++; if (!ok || g !== 5'b00001) begin errors++; $display("FAIL midrst_priority got=%b ok=%0d exp=00001", g, ok); end
        bus.in_req = '0;
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        port_vec_t g; word_t d; int lat; int ac; bit ok;
        bus.in_data[2] = 32'hEA41_0002;
        bus.in_req = 5'b00100;
        handshake(1'b1, '0, g, d, lat, ac, ok);
        checks++; if (!ok) begin errors++; $display("FAIL early_handshake got=0 exp=1"); end
        checks++; if (d !== 32'hEA41_0002 || g !== 5'b00100) begin errors++; $display("FAIL early_word got=%h grant=%b exp=ea410002 grant=00100", d, g); end
        checks++; if (ac !== 1) begin errors++; $display("FAIL early_ack_len got=%0d exp=1", ac); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL early_idle got=%b exp=0", bus.busy); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_req  = '0;
        bus.out_ack = 1'b0;
        for (int i = 0; i < P; i++) bus.in_data[i] = '0;
        test_reset();
        mon_en = 1'b1;
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_late_request();
        test_reset_mid();
        test_early_drop();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Round-robin arbiter and sequencer for one router output channel. Shares a single outgoing req/ack link between the router's input ports and runs a four-phase handshake on both sides. Each grant moves one n-bit word. One instance sits in front of each output direction of a router tile.

## Interface
- n, 32, data word width
- P, 5, number of requesting input ports; index order follows router_pkg port enum (LOCAL, NORTH, SOUTH, EAST, WEST)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_req  in  P  per-port request, four-phase
- in_data  in  P×n  per-port data; must be stable while that port's in_req is high
- in_ack  out  P  per-port acknowledge; at most one bit high at any time
- out_req  out  1  request to downstream link
- out_data  out  n  registered word to downstream link
- out_ack  in  1  downstream acknowledge
- grant  out  P  one-hot current owner; all zero when idle
- busy  out  1  high in every state except IDLE

## Operation
- FSM states, in order:
  - IDLE
    - If any in_req bit is high, pick a winner with the round-robin rule.
    - Latch in_data[winner] into out_data.
    - Set grant to the winner and out_req to 1.
    - Go to SEND.
  - SEND
    - Hold out_req = 1 and hold out_data.
    - When out_ack = 1: set out_req to 0 and go to DROP.
  - DROP
    - When out_ack = 0: set in_ack[winner] to 1 and go to RET.
  - RET
    - When in_req[winner] = 0: set in_ack to 0, load ptr with winner, clear grant, go to IDLE.
- Round-robin rule:
  - Search starts at (ptr+1) mod P and wraps around.
  - The first port with in_req high wins.
  - ptr resets to P-1, so port 0 has top priority after reset.
  - Wrap-around example with P=5: ptr=4 means the search order is 0,1,2,3,4.
- Requests arriving during a transaction wait. They are not lost, and the winner is not re-evaluated until the FSM is back in IDLE.
- Simultaneous requests are resolved only by the pointer. The last-served port has lowest priority in the next arbitration.
- Protocol violation: the winner drops in_req before in_ack rises.
  - The word is already latched, so the downstream transfer completes.
  - On reaching RET with in_req already 0, in_ack pulses for exactly one cycle.
- out_data holds its last value while idle. Downstream must ignore it unless out_req = 1.

## Timing
- Reset values: out_req=0, out_data=0, in_ack=0, grant=0, busy=0, state=IDLE, ptr=P-1.
- rst has priority over everything. Asserted mid-transaction, it aborts the transaction: on the next edge all outputs take their reset values.
- Every output is driven from a register; there is no combinational path from an input to an output.
- Latency, with in_req sampled high at edge t while IDLE:
  - out_req and grant high after edge t, i.e. visible during cycle t+1.
  - out_ack sampled high at edge u: out_req low after u.
  - out_ack sampled low at edge v: in_ack high after v.
  - in_req sampled low at edge w: in_ack low and FSM in IDLE after w.
  - A new arbitration can happen at edge w+1 at the earliest.
- Minimum full transaction is 4 cycles when the environment answers in 0 extra cycles. Sustained throughput is at most one word per 4 cycles.
- No timeouts: each wait state waits indefinitely.

## Structure
- router_pkg holds:
  - port index enum and P constant
  - arb_state_t enum (IDLE, SEND, DROP, RET)
- rr_arbiter sub-module, purely combinational:
  - inputs: req[P], ptr
  - outputs: one-hot gnt[P], idx, any
- router_out_arbiter owns the FSM, ptr, the data latch and the ack generation.
- Expected size: about 180 RTL lines.

## Test plan
- Reset, then a single request:
  - Stimulus: in_req=00100, data 32'hA5A5_0001.
  - Response: out_req rises the cycle after; out_data=32'hA5A5_0001; grant=00100.
  - After out_ack toggles high then low, in_ack[2] rises; after in_req[2] drops, IDLE.
- All five ports request continuously from reset:
  - Grant order is 0,1,2,3,4,0.
  - in_ack is never high on two ports at once.
- Pointer wrap:
  - Serve port 4, then request ports 0 and 3 simultaneously: port 0 wins.
- Late request:
  - Port 1 raises in_req while port 3 is in SEND.
  - Port 1 is served only after port 3's RET completes; port 3's word is unchanged.
- Reset mid-operation:
  - Assert rst while in DROP.
  - The next cycle shows out_req=0, in_ack=0, grant=0, busy=0.
  - After release, port 0 has priority.
- Early in_req drop:
  - Winner drops in_req while in SEND.
  - Downstream still receives the word; in_ack is high for exactly 1 cycle; FSM returns to IDLE.
